// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like request/addr_ok/data_ok interface:
// access size encodings, responder state type and the byte-lane mask helper.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} resp_state_t;

  // Byte write enables for an access of the given size at byte offset addr_lo.
  // Size 2'b11 is treated as a word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << addr_lo;
      SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sram_like_mem_resp_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to inject random acceptance stalls.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  // Seeded on reset, shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) q <= 8'hA5;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/sram_like_mem_resp.sv
// sram-like memory responder: accepts one request at a time, performs a
// byte-masked access on a 1-cycle-latency synchronous RAM and pulses data_ok
// LATENCY cycles after acceptance.
// Optional: define SRAM_RESP_RAND_STALL_EN to stall acceptance pseudo-randomly.
module sram_like_mem_resp
  import sram_like_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  resp_state_t state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        accept;

  // Address bits above the RAM word index are intentionally ignored (wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [7:0] lfsr;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign accept = (state == IDLE) & req & ~rst & ~lfsr[0];
`else
  assign accept = (state == IDLE) & req & ~rst;
`endif

  assign addr_ok = accept;
  assign rdata   = rdata_q;

  // Responder FSM. The RAM command is registered straight from the accepted
  // request so it is presented during the first BUSY cycle; the ram_addr and
  // ram_wdata registers double as the latched request address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      data_ok   <= 1'b0;
      rdata_q   <= 32'd0;
      ram_en    <= 1'b0;
      ram_we    <= 4'b0000;
      ram_addr  <= '0;
      ram_wdata <= 32'd0;
    end else begin
      ram_en <= accept;
      ram_we <= (accept && wr) ? byte_mask(size, addr[1:0]) : 4'b0000;
      case (state)
        IDLE: begin
          data_ok <= 1'b0;
          if (accept) begin
            wr_q      <= wr;
            ram_addr  <= addr[ADDR_W+1:2];
            ram_wdata <= wdata;
            cnt       <= 4'd1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // RAM data is valid the cycle after ram_en, i.e. when cnt==2.
          if (cnt == 4'd2 && !wr_q) rdata_q <= ram_rdata;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(LATENCY - 1)) begin
            state   <= DONE;
            data_ok <= 1'b1;
          end
        end
        DONE: begin
          data_ok <= 1'b0;
          cnt     <= 4'd0;
          state   <= IDLE;
        end
        default: begin
          data_ok <= 1'b0;
          cnt     <= 4'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
